// File: rtl/rev_gate_arbiter.sv
// Two-requester arbiter/sequencer for a shared clocked reversible gate stage.
// Define REV_ARB_RR_EN for round-robin arbitration; the default is fixed priority with requester 0 first.
module rev_gate_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned GATE_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [WIDTH-1:0] gate_a,
  output logic [WIDTH-1:0] gate_b,
  input  logic [WIDTH-1:0] gate_p,
  input  logic [WIDTH-1:0] gate_q,
  input  logic [WIDTH-1:0] gate_r,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_p,
  output logic [WIDTH-1:0] rsp_q,
  output logic [WIDTH-1:0] rsp_r,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [3:0] cnt;
  logic       grant;
  logic       accept;

`ifdef REV_ARB_RR_EN
  logic ptr;

  always_comb begin
    grant = (req_valid == 2'b11) ? ptr : req_valid[1];
  end
`else
  always_comb begin
    grant = ~req_valid[0];
  end
`endif

  always_comb begin
    state_n   = state;
    req_ready = '0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rst && req_valid[grant]) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_n          = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) state_n = RESP;
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // WAIT spans GATE_LAT+1 cycles: the gate output reflects gate_a/gate_b
  // only GATE_LAT edges after they change, so capture happens one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_a <= '0;
      gate_b <= '0;
      rsp_id <= 1'b0;
      rsp_p  <= '0;
      rsp_q  <= '0;
      rsp_r  <= '0;
      cnt    <= '0;
`ifdef REV_ARB_RR_EN
      ptr    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        gate_a <= grant ? req_a1 : req_a0;
        gate_b <= grant ? req_b1 : req_b0;
        rsp_id <= grant;
        cnt    <= 4'(GATE_LAT);
`ifdef REV_ARB_RR_EN
        ptr    <= ~grant;
`endif
      end
      if (state == WAIT) begin
        if (cnt == '0) begin
          rsp_p <= gate_p;
          rsp_q <= gate_q;
          rsp_r <= gate_r;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_rev_gate_arbiter.sv
// Bench for rev_gate_arbiter: gate stub, transaction-level reference model, directed scenarios.
// Honors REV_ARB_RR_EN the same way the design does.
module tb_rev_gate_arbiter #(
  parameter int unsigned LAT = 3
);
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [W-1:0] gate_a, gate_b, gate_p, gate_q, gate_r;
  logic         rsp_valid, rsp_ready, rsp_id, busy;
  logic [W-1:0] rsp_p, rsp_q, rsp_r;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  bit seen_r1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rev_gate_arbiter #(.WIDTH(W), .GATE_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .gate_a(gate_a), .gate_b(gate_b),
    .gate_p(gate_p), .gate_q(gate_q), .gate_r(gate_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_p(rsp_p), .rsp_q(rsp_q), .rsp_r(rsp_r),
    .busy(busy)
  );

  // Gate stub: LAT register stages of P=A^B, Q=A&B, R=A|B.
  logic [W-1:0] sp[LAT], sq[LAT], sr[LAT];
  always @(posedge clk) begin
    sp[0] <= gate_a ^ gate_b;
    sq[0] <= gate_a & gate_b;
    sr[0] <= gate_a | gate_b;
    for (int i = 1; i < int'(LAT); i++) begin
      sp[i] <= sp[i-1];
      sq[i] <= sq[i-1];
      sr[i] <= sr[i-1];
    end
  end
  assign gate_p = sp[LAT-1];
  assign gate_q = sq[LAT-1];
  assign gate_r = sr[LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one in-flight transaction with an age in edges since accept.
  bit           m_busy = 1'b0;
  bit           m_id   = 1'b0;
  bit           m_ptr  = 1'b0;
  int           m_age  = 0;
  logic [W-1:0] m_a  = '0, m_b  = '0;
  logic [W-1:0] m_ga = '0, m_gb = '0;

  function automatic bit mgrant();
    if (req_valid == 2'b01) return 1'b0;
    if (req_valid == 2'b10) return 1'b1;
`ifdef REV_ARB_RR_EN
    return m_ptr;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit g;
    if (rst) begin
      m_busy <= 1'b0; m_id <= 1'b0; m_ptr <= 1'b0; m_age <= 0;
      m_ga <= '0; m_gb <= '0;
    end else if (!m_busy) begin
      if (req_valid != 2'b00) begin
        g = mgrant();
        m_busy <= 1'b1;
        m_id   <= g;
        m_age  <= 0;
        m_ptr  <= !g;
        m_a    <= g ? req_a1 : req_a0;
        m_b    <= g ? req_b1 : req_b0;
        m_ga   <= g ? req_a1 : req_a0;
        m_gb   <= g ? req_b1 : req_b0;
      end
    end else if (m_age >= int'(LAT) + 1) begin
      if (rsp_ready) m_busy <= 1'b0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin : cmp
    logic [1:0] er;
    logic       ev;
    er = (!rst && !m_busy && req_valid != 2'b00) ? (mgrant() ? 2'b10 : 2'b01) : 2'b00;
    ev = !rst && m_busy && (m_age >= int'(LAT) + 1);
    chk("req_ready", {30'd0, req_ready}, {30'd0, er});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
    chk("busy", {31'd0, busy}, {31'd0, (!rst && m_busy)});
    chk("gate_a", gate_a, m_ga);
    chk("gate_b", gate_b, m_gb);
    if (ev) begin
      chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
      chk("rsp_p", rsp_p, m_a ^ m_b);
      chk("rsp_q", rsp_q, m_a & m_b);
      chk("rsp_r", rsp_r, m_a | m_b);
    end
    if (req_ready[1]) seen_r1 = 1'b1;
  end

  // Returns #1 after the accept edge; c is the accept cycle.
  task automatic wait_grant(input int who, output int c);
    c = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready[who]) begin
        c = cyc;
        @(posedge clk); #1;
        return;
      end
    end
    chk("grant_timeout", 32'd0, 32'd1);
  endtask

  // Returns at the negedge of the first cycle with rsp_valid high.
  task automatic wait_valid(output int c);
    c = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        c = cyc;
        return;
      end
    end
    chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_rsp(input string nm, input bit id, input logic [31:0] p,
                         input logic [31:0] q, input logic [31:0] r);
    chk({nm, "_id"}, {31'd0, rsp_id}, {31'd0, id});
    chk({nm, "_p"}, rsp_p, p);
    chk({nm, "_q"}, rsp_q, q);
    chk({nm, "_r"}, rsp_r, r);
  endtask

  initial begin : stim
    int ac, vc;
    bit eid;
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    @(negedge clk);
    chk("reset_ready", {30'd0, req_ready}, 32'd0);
    chk("reset_gate_a", gate_a, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single request
    req_a0 = 32'hA5A5A5A5; req_b0 = 32'h5A5A5A5A; req_valid = 2'b01;
    wait_grant(0, ac);
    req_valid = 2'b00;
    chk("single_busy", {31'd0, busy}, 32'd1);
    chk("single_gate_a", gate_a, 32'hA5A5A5A5);
    wait_valid(vc);
    chk("single_latency", 32'(vc - ac), 32'(LAT + 2));
    chk_rsp("single", 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF);
    @(posedge clk); #1;
    chk("single_busy_after", {31'd0, busy}, 32'd0);

    // Contention after a fresh reset
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    req_a0 = 32'h12345678; req_b0 = 32'h87654321;
    req_a1 = 32'hFFFFFFFF; req_b1 = 32'h00000000;
    seen_r1 = 1'b0;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_valid(vc);
`ifdef REV_ARB_RR_EN
      eid = k[0];
`else
      eid = 1'b0;
`endif
      if (eid) chk_rsp("cont", 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF);
      else     chk_rsp("cont", 1'b0, 32'h95511559, 32'h02244220, 32'h97755779);
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
`ifdef REV_ARB_RR_EN
    chk("cont_r1_granted", {31'd0, seen_r1}, 32'd1);
`else
    chk("cont_r1_starved", {31'd0, seen_r1}, 32'd0);
`endif

    // Backpressure
    rsp_ready = 1'b0;
    req_a0 = 32'h0F0F0F0F; req_b0 = 32'hF0F0F0F0; req_valid = 2'b01;
    wait_grant(0, ac);
    req_valid = 2'b10;
    wait_valid(vc);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_p", rsp_p, 32'hFFFFFFFF);
      chk("bp_ready", {30'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_last", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    chk("bp_transfer", {31'd0, rsp_valid}, 32'd0);
    wait_grant(1, ac);
    req_valid = 2'b00;
    wait_valid(vc);
    chk_rsp("bp_r1", 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF);
    @(posedge clk); #1;

    // Reset mid-WAIT
    req_a0 = 32'hCAFEF00D; req_b0 = 32'h12345678; req_valid = 2'b01;
    wait_grant(0, ac);
    req_valid = 2'b00;
    rst = 1'b1; req_valid = 2'b11;
    #2;
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_gate_a", gate_a, 32'd0);
    chk("rst_gate_b", gate_b, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk_rsp("rst", 1'b0, 32'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 2'b00;
    for (int i = 0; i < int'(LAT) + 4; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    req_a0 = 32'h0000FFFF; req_b0 = 32'h00FF00FF;
    req_a1 = 32'hFFFFFFFF; req_b1 = 32'h00000000;
    @(posedge clk); #1 req_valid = 2'b11;
    @(negedge clk);
    chk("rr_restart", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = 2'b10;
    wait_valid(vc);
    chk_rsp("rst_r0", 1'b0, 32'h00FFFF00, 32'h000000FF, 32'h00FFFFFF);
    @(posedge clk); #1;
    wait_grant(1, ac);
    req_valid = 2'b00;
    wait_valid(vc);
    chk_rsp("rst_r1", 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF);
    @(posedge clk); #1;

    // Operand hold: req0 waits behind req1 while its operands change
    req_valid = 2'b10;
    wait_grant(1, ac);
    req_a0 = 32'h11111111; req_b0 = 32'h00000000; req_valid = 2'b11;
    @(posedge clk); #1 req_a0 = 32'h22222222;
    wait_valid(vc);
    chk("hold_r1_id", {31'd0, rsp_id}, 32'd1);
    @(posedge clk); #1;
    wait_grant(0, ac);
    req_a0 = 32'h33333333; req_valid = 2'b00;
    wait_valid(vc);
    chk_rsp("hold", 1'b0, 32'h22222222, 32'h00000000, 32'h22222222);
    chk("hold_gate_a", gate_a, 32'h22222222);
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
